// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised asynchronous serial receiver. Samples the rx line at mid-bit
// using a baud counter derived from CLOCK_FREQUENCY / BAUD_RATE. It supports
// 5..9 data bits (LSB first), optional odd/even parity and one or two stop
// bits. It reports parity and framing errors and rejects false start bits.
//
// Parameters:
//   CLOCK_FREQUENCY  system clock in Hz
//   BAUD_RATE        line rate in bit/s (CYC = CLOCK_FREQUENCY / BAUD_RATE >= 8)
//   DATA_BITS        data bits per frame, 5..9
//   PARITY           0 = none, 1 = odd, 2 = even
//   STOP_BITS        1 or 2
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   rx             in   serial line, idle high, asynchronous to clock
//   byte_data      out  last received word, held until the next frame
//   byte_ready     out  one-cycle pulse when a frame completes
//   parity_error   out  parity flag, valid only with byte_ready
//   framing_error  out  stop-bit flag, valid only with byte_ready
//
// Optional build macro:
//   UART_RX_MAJORITY_EN  when defined, each sample point is a 2-of-3 majority
//                        of rxs at strobe-1, strobe and strobe+1. The decision
//                        is taken at strobe+1, so byte_ready is one cycle later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_param #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned BAUD_RATE       = 9600,
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned PARITY          = 0,
   parameter int unsigned STOP_BITS       = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] byte_data,
   output logic                 byte_ready,
   output logic                 parity_error,
   output logic                 framing_error
);

   localparam int unsigned CYC  = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int unsigned HALF = CYC / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Synchroniser and edge history
   logic rx_meta_q;
   logic rxs_q;
   logic rxs_prev_q;

   state_t               state_q,     state_d;
   logic [31:0]          cnt_q,       cnt_d;
   logic [3:0]           bit_cnt_q,   bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q,     shreg_d;
   logic                 perr_acc_q,  perr_acc_d;
   logic                 ferr_acc_q,  ferr_acc_d;
   logic [DATA_BITS-1:0] byte_data_q, byte_data_d;
   logic                 ready_q,     ready_d;
   logic                 perr_q,      perr_d;
   logic                 ferr_q,      ferr_d;

   logic start_edge;
   logic strobe;
   logic sample_en;
   logic sample_bit;

   // NOTE: every flop, including the sync chain and the shift register, is
   // reset; the sync flops reset to 1 so release never looks like a start edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make each flop take the value its
         // neighbour had before the edge, which is what forms the shift chain.
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   assign start_edge = rxs_prev_q & ~rxs_q;
   assign strobe     = (state_q != S_IDLE) && (cnt_q == 32'd1);

`ifdef UART_RX_MAJORITY_EN
   logic rxs_prev2_q;
   logic strobe_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rxs_prev2_q <= 1'b1;
         strobe_q    <= 1'b0;
      end else begin
         rxs_prev2_q <= rxs_prev_q;
         strobe_q    <= strobe;
      end
   end

   // One cycle after the strobe: rxs_prev2_q = strobe-1, rxs_prev_q = strobe,
   // rxs_q = strobe+1.
   assign sample_en  = strobe_q;
   assign sample_bit = (rxs_prev2_q & rxs_prev_q) |
                       (rxs_prev_q  & rxs_q)      |
                       (rxs_prev2_q & rxs_q);
`else
   assign sample_en  = strobe;
   assign sample_bit = rxs_q;
`endif

   // Baud counter. It reloads at every strobe even when the decision is
   // deferred by the majority vote, so the bit grid never drifts.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q > 32'd1) begin
         cnt_d = cnt_q - 32'd1;
      end
      if ((state_q == S_IDLE) && start_edge) begin
         cnt_d = HALF;
      end else if (strobe) begin
         cnt_d = CYC;
      end
   end

   // NOTE: every variable gets a default before the case statement, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      logic par_calc;
      logic ferr_now;

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      perr_acc_d  = perr_acc_q;
      ferr_acc_d  = ferr_acc_q;
      byte_data_d = byte_data_q;
      ready_d     = 1'b0;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
      par_calc    = 1'b0;
      ferr_now    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d    = S_START;
               bit_cnt_d  = 4'd0;
               perr_acc_d = 1'b0;
               ferr_acc_d = 1'b0;
            end
         end

         S_START: begin
            if (sample_en) begin
               // A high line at mid-start means a glitch, not a frame.
               state_d = sample_bit ? S_IDLE : S_DATA;
            end
         end

         S_DATA: begin
            if (sample_en) begin
               shreg_d = {sample_bit, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = 4'd0;
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end

         S_PARITY: begin
            if (sample_en) begin
               par_calc   = (^shreg_q) ^ sample_bit;
               perr_acc_d = (PARITY == 1) ? ~par_calc : par_calc;
               state_d    = S_STOP;
            end
         end

         S_STOP: begin
            if (sample_en) begin
               ferr_now = ferr_acc_q | ~sample_bit;
               if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  // Return to IDLE at mid-stop so a start edge in the last
                  // half stop bit is still caught.
                  byte_data_d = shreg_q;
                  ready_d     = 1'b1;
                  perr_d      = perr_acc_q;
                  ferr_d      = ferr_now;
                  bit_cnt_d   = 4'd0;
                  state_d     = S_IDLE;
               end else begin
                  ferr_acc_d = ferr_now;
                  bit_cnt_d  = bit_cnt_q + 4'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 32'd0;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= '0;
         perr_acc_q  <= 1'b0;
         ferr_acc_q  <= 1'b0;
         byte_data_q <= '0;
         ready_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         perr_acc_q  <= perr_acc_d;
         ferr_acc_q  <= ferr_acc_d;
         byte_data_q <= byte_data_d;
         ready_q     <= ready_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   assign byte_data     = byte_data_q;
   assign byte_ready    = ready_q;
   assign parity_error  = perr_q;
   assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//
// Directed bench for uart_rx_param at CLOCK_FREQUENCY=1600, BAUD_RATE=100
// (CYC=16, HALF=8). u_dut0 has no parity; u_dut1 uses even parity. Both have
// 8 data bits and 1 stop bit and share clock and reset. Frame timing is
// measured from the cycle the start bit is driven onto rx. The two-flop
// synchroniser adds 2 cycles, so T = drive + 2.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_param;

`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ_LAT = 1;
`else
   localparam int MAJ_LAT = 0;
`endif
   // drive-to-ready: 2 sync cycles + HALF + (samples-1)*CYC + 1
   localparam int LAT_NOPAR = 2 + 8 + 9 * 16 + 1 + MAJ_LAT;   // 155
   localparam int LAT_PAR   = 2 + 8 + 10 * 16 + 1 + MAJ_LAT;  // 171

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx0     = 1'b1;
   logic       rx1     = 1'b1;
   logic [7:0] data0, data1;
   logic       ready0, ready1, pe0, pe1, fe0, fe1;

   uart_rx_param #(
      .CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1)
   ) u_dut0 (
      .clock(clock), .reset_n(reset_n), .rx(rx0),
      .byte_data(data0), .byte_ready(ready0),
      .parity_error(pe0), .framing_error(fe0)
   );

   uart_rx_param #(
      .CLOCK_FREQUENCY(1600), .BAUD_RATE(100), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1)
   ) u_dut1 (
      .clock(clock), .reset_n(reset_n), .rx(rx1),
      .byte_data(data1), .byte_ready(ready1),
      .parity_error(pe1), .framing_error(fe1)
   );

   always #5 clock = ~clock;

   int cyc_cnt = 0;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } rec_t;

   rec_t q0[$];
   rec_t q1[$];
   int   leak = 0;   // cycles with an error flag high while byte_ready is low

   function automatic rec_t mk_rec(input int c, input logic [7:0] d,
                                   input logic p, input logic f);
      rec_t r;
      r.cyc  = c;
      r.data = d;
      r.pe   = p;
      r.fe   = f;
      return r;
   endfunction

   // Every high cycle of byte_ready is logged, so a 2-cycle pulse shows up
   // as an extra record.
   always @(negedge clock) begin
      if (ready0) q0.push_back(mk_rec(cyc_cnt, data0, pe0, fe0));
      else if (pe0 || fe0) leak++;
      if (ready1) q1.push_back(mk_rec(cyc_cnt, data1, pe1, fe1));
      else if (pe1 || fe1) leak++;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx0 = v;
      else            rx1 = v;
   endtask

   // Called at #1 after an edge; holds one bit for 16 cycles and returns at
   // #1 after the 16th edge. With glitch set, the level is inverted for the
   // single cycle that reaches rxs exactly at the sample strobe.
   task automatic drive_bit(input int which, input logic v, input bit glitch);
      set_rx(which, v);
      if (glitch) begin
         repeat (8) @(posedge clock);
         #1 set_rx(which, ~v);
         @(posedge clock);
         #1 set_rx(which, v);
         repeat (7) @(posedge clock);
      end else begin
         repeat (16) @(posedge clock);
      end
      #1;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d,
                             input bit use_par, input logic par_bit,
                             input logic stop_bit, input bit glitch,
                             output int start_cyc);
      @(posedge clock);
      #1 start_cyc = cyc_cnt;
      drive_bit(which, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i], glitch);
      if (use_par) drive_bit(which, par_bit, 1'b0);
      drive_bit(which, stop_bit, 1'b0);
      set_rx(which, 1'b1);
   endtask

   task automatic check_rec(input string tag, input rec_t r, input int start,
                            input int lat, input logic [7:0] d,
                            input logic p, input logic f);
      check({tag, "_latency"}, r.cyc - start, lat);
      check({tag, "_data"}, {24'd0, r.data}, {24'd0, d});
      check({tag, "_perr"}, {31'd0, r.pe}, {31'd0, p});
      check({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, f});
   endtask

   // Expects exactly one logged pulse on the selected DUT and checks it.
   task automatic expect_one(input string tag, input int which, input int start,
                             input int lat, input logic [7:0] d,
                             input logic p, input logic f);
      int   n;
      rec_t r;
      @(negedge clock);
      n = (which == 0) ? q0.size() : q1.size();
      check({tag, "_pulses"}, n, 1);
      if (n > 0) begin
         r = (which == 0) ? q0.pop_front() : q1.pop_front();
         check_rec(tag, r, start, lat, d, p, f);
      end
      q0.delete();
      q1.delete();
   endtask

   initial begin
      int   s, s2;
      bit   maj_glitch;
      rec_t r;
`ifdef UART_RX_MAJORITY_EN
      maj_glitch = 1'b1;
`else
      maj_glitch = 1'b0;
`endif

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_data", {24'd0, data0}, 32'h0);
      check("rst_ready", {31'd0, ready0}, 32'h0);
      check("rst_perr", {31'd0, pe0}, 32'h0);
      check("rst_ferr", {31'd0, fe0}, 32'h0);
      check("rst_data_par", {24'd0, data1}, 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clock);

      // 1. plain frame 0xA5
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, s);
      expect_one("t1", 0, s, LAT_NOPAR, 8'hA5, 1'b0, 1'b0);
      repeat (20) @(posedge clock);
      @(negedge clock);
      check("t1_hold_data", {24'd0, data0}, 32'hA5);
      check("t1_ready_low", {31'd0, ready0}, 32'h0);

      // 2. even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, s);
      expect_one("t2_bad", 1, s, LAT_PAR, 8'h03, 1'b1, 1'b0);
      repeat (5) @(posedge clock);
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, s);
      expect_one("t2_good", 1, s, LAT_PAR, 8'h03, 1'b0, 1'b0);

      // 3. framing error, then a clean frame
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, s);
      expect_one("t3_bad", 0, s, LAT_NOPAR, 8'h55, 1'b0, 1'b1);
      repeat (5) @(posedge clock);
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, s);
      expect_one("t3_good", 0, s, LAT_NOPAR, 8'h0F, 1'b0, 1'b0);

      // 4. 4-cycle low glitch is a false start
      @(posedge clock);
      #1 rx0 = 1'b0;
      repeat (4) @(posedge clock);
      #1 rx0 = 1'b1;
      repeat (40) @(posedge clock);
      @(negedge clock);
      check("t4_no_pulse", q0.size(), 0);
      check("t4_data_kept", {24'd0, data0}, 32'h0F);
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, s);
      expect_one("t4_frame", 0, s, LAT_NOPAR, 8'h3C, 1'b0, 1'b0);

      // 5. back-to-back: second start edge 9 cycles after first stop sample
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, s);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, s2);
      check("t5_gap", s2 - s, 161);
      repeat (20) @(posedge clock);
      @(negedge clock);
      check("t5_pulses", q0.size(), 2);
      if (q0.size() == 2) begin
         r = q0.pop_front();
         check_rec("t5_a", r, s, LAT_NOPAR, 8'h11, 1'b0, 1'b0);
         r = q0.pop_front();
         check_rec("t5_b", r, s2, LAT_NOPAR, 8'h22, 1'b0, 1'b0);
      end
      q0.delete();

      // 6. reset during data bit 4 of a frame
      @(posedge clock);
      #1;
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      rx0 = 1'b1;
      reset_n = 1'b0;
      @(negedge clock);
      check("t6_rst_data", {24'd0, data0}, 32'h0);
      check("t6_rst_ready", {31'd0, ready0}, 32'h0);
      check("t6_rst_data_par", {24'd0, data1}, 32'h0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (200) @(posedge clock);
      @(negedge clock);
      check("t6_no_pulse", q0.size(), 0);
      send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, maj_glitch, s);
      expect_one("t6_frame", 0, s, LAT_NOPAR, 8'h7E, 1'b0, 1'b0);

      check("flag_leak", leak, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised asynchronous serial receiver; successor to the fixed 8N1 receiver. Supports configurable data width, optional parity and one or two stop bits. Reports parity and framing errors and rejects false start bits. Sits between the board rx pin and the byte consumers (sensor-packet parser, MIPSfpga peripheral bridge).

Parameters:
CLOCK_FREQUENCY, 50000000, system clock in Hz
BAUD_RATE, 9600, line rate in bit/s; CYC = CLOCK_FREQUENCY / BAUD_RATE (integer divide), HALF = CYC / 2; CYC >= 8 required
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clock
byte_data  output  DATA_BITS  last received word, LSB = first data bit on the line
byte_ready  output  1  one-cycle pulse: new byte_data and error flags valid
parity_error  output  1  valid only while byte_ready=1; 0 otherwise
framing_error  output  1  valid only while byte_ready=1; 0 otherwise

Behaviour:
- One clock domain; reset is asynchronous and active-low, applied to every flop.
- Reset values: byte_data=0, byte_ready=0, parity_error=0, framing_error=0, FSM=IDLE, counter=0, sync flops=1.
- rx passes through a 2-flop synchroniser; rxs = second flop. Start edge = prev(rxs)=1 and rxs=0. T = the cycle in which the edge is seen.
- Bit counter: loads on each event and decrements to 1. Sample strobe fires when counter==1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on start edge, load HALF -> START. rxs low without an edge (line stuck low) does not start a frame.
- START: samples at T+HALF. rxs=1 -> false start, back to IDLE, no byte_ready. rxs=0 -> load CYC -> DATA.
- DATA: bit i is sampled at T+HALF+(i+1)*CYC and shifted into a DATA_BITS shift register, LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: one sample. Error if the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
- STOP: STOP_BITS samples, each CYC apart. Any stop sample = 0 sets the framing flag; all samples are still taken.
- After the last stop sample: byte_data, parity_error and framing_error are registered, and byte_ready=1 for exactly the next cycle.
  - FSM returns to IDLE in that same cycle, i.e. at mid-stop-bit. A start edge arriving in the remaining half stop bit is accepted.
- byte_data holds its value until the next completed frame, including frames with errors. Flags pulse with byte_ready only.
- Total latency: byte_ready high at cycle T + HALF + (1+DATA_BITS+P+STOP_BITS-1)*CYC + 1, where P=1 if parity enabled, else 0.
- Start edges in any non-IDLE state are ignored.
- reset_n low mid-frame: immediately IDLE with all outputs at reset values. A partial frame is discarded, and no byte_ready occurs after release until a full new frame arrives.
- Counter is 32 bits; no wrap for any legal parameters.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample point (start, data, parity, stop) takes three rxs samples at strobe-1, strobe and strobe+1 cycles. The value used is the majority of the three, decided at strobe+1. The FSM decision and all subsequent timing shift by +1 cycle, so byte_ready is 1 cycle later.
- Undefined: single sample at the strobe cycle.

Test Plan (CLOCK_FREQUENCY=1600, BAUD_RATE=100, CYC=16):
1. DATA_BITS=8, PARITY=0, frame 0xA5 with good stop -> byte_ready pulse 1 cycle wide at T+8+9*16+1=T+153; byte_data=0xA5; both flags 0.
2. PARITY=2, 0x03 with parity bit 1 -> byte_data=0x03, parity_error=1, framing_error=0. Same frame with parity bit 0 -> parity_error=0.
3. 0x55 with stop bit driven 0 -> byte_ready=1, framing_error=1, byte_data=0x55. Then a good frame 0x0F -> framing_error=0, byte_data=0x0F.
4. rx low for 4 cycles then high (glitch) -> no byte_ready; a following valid frame 0x3C is received correctly.
5. Back-to-back frames 0x11 then 0x22, second start edge 9 cycles after the first stop sample -> two byte_ready pulses, data 0x11 then 0x22.
6. reset_n pulsed low during data bit 4 -> outputs 0 and no pulse for the aborted frame; next frame 0x7E received. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at the centre of each data bit of 0x7E still yields 0x7E.
